// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined 16-bit CPU.
// Word RAM, MMIO window (output port, cycle counter) and sticky error flags.
// After reset an init sequence zeroes the RAM before ready is raised.
module dmem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [15:0] IOPORT_A = 16'hFFFC,
  parameter logic [15:0] CYCLES_A = 16'hFFFE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic        ready,
  output logic [15:0] ioport,
  output logic        err_misalign,
  output logic        err_range
);

  localparam int unsigned IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] RAM_BYTES = 16'(2 * DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t          state;
  logic [IDXW-1:0] clear_idx;
  logic [15:0]     cycles;
  logic [15:0]     mem [DEPTH];

  logic            access;
  logic            is_odd;
  logic            is_ram;
  logic            is_io;
  logic            is_cyc;
  logic            is_unmapped;
  logic [IDXW-1:0] word_idx;

  // Address decode; odd addresses never reach a target.
  always_comb begin
    access      = dmemread | dmemwrite;
    is_odd      = dmemaddr[0];
    is_ram      = !is_odd && (dmemaddr < RAM_BYTES);
    is_io       = !is_odd && (dmemaddr == IOPORT_A);
    is_cyc      = !is_odd && (dmemaddr == CYCLES_A);
    is_unmapped = !is_odd && !is_ram && !is_io && !is_cyc;
    word_idx    = dmemaddr[IDXW:1];
  end

  // Same-cycle read path; returns pre-write contents on a read+write collision.
  always_comb begin
    dmemrdata = 16'h0000;
    if (ready && dmemread) begin
      if (is_ram)      dmemrdata = mem[word_idx];
      else if (is_io)  dmemrdata = ioport;
      else if (is_cyc) dmemrdata = cycles;
    end
  end

  // Init/run sequencing, MMIO registers, cycle counter and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INIT;
      clear_idx    <= '0;
      ready        <= 1'b0;
      ioport       <= 16'h0000;
      cycles       <= 16'h0000;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clear_idx <= clear_idx + IDXW'(1);
          if (clear_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          cycles <= cycles + 16'd1;
          if (dmemwrite && is_io)      ioport       <= dmemwdata;
          if (access && is_odd)        err_misalign <= 1'b1;
          if (access && is_unmapped)   err_range    <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // RAM port: zero-fill during init, CPU writes in run; nothing written on a reset edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT)            mem[clear_idx] <= 16'h0000;
      else if (dmemwrite && is_ram) mem[word_idx]  <= dmemwdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256).
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic        ready;
  logic [15:0] ioport;
  logic        err_misalign;
  logic        err_range;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(256)) dut (
    .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite), .dmemread(dmemread), .dmemrdata(dmemrdata),
    .ready(ready), .ioport(ioport), .err_misalign(err_misalign), .err_range(err_range)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    dmemwrite = 1'b0;
    dmemread  = 1'b0;
    dmemaddr  = 16'h0000;
    dmemwdata = 16'h0000;
  endtask

  // Count edges until ready (bounded); also counts nonzero reads seen while not ready.
  task automatic wait_ready(output int n, output int bad);
    n = 0;
    bad = 0;
    while (!ready && n < 400) begin
      if (dmemrdata !== 16'h0000) bad++;
      tick();
      n++;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    dmemaddr = a; dmemwdata = d; dmemwrite = 1'b1; dmemread = 1'b0;
    tick();
    dmemwrite = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    dmemaddr = a; dmemread = 1'b1; dmemwrite = 1'b0;
    #1;
    d = dmemrdata;
  endtask

  task automatic test_reset;
    int n, bad;
    logic [15:0] d;
    idle();
    reset = 1'b1;
    dmemwrite = 1'b1; dmemaddr = 16'h0010; dmemwdata = 16'h5A5A;
    tick(); tick();
    reset = 1'b0;
    dmemwrite = 1'b0; dmemread = 1'b1; dmemaddr = 16'h00FE;
    #1;
    checks++;
    if (ready !== 1'b0 || ioport !== 16'h0 || err_misalign !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b ioport=%h errm=%b errr=%b, want 0/0000/0/0",
               ready, ioport, err_misalign, err_range);
    end
    wait_ready(n, bad);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL init_latency: ready after %0d edges, want 256", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_read_zero: %0d nonzero reads during init, want 0", bad);
    end
    cpu_read(16'h00FE, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL ram_zeroed: read %h, want 0000", d);
    end
    cpu_read(16'hFFFE, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL cycles_start: read %h, want 0000", d);
    end
    idle();
  endtask

  task automatic test_ram;
    logic [15:0] d;
    cpu_write(16'h0010, 16'h1234);
    cpu_read(16'h0010, d);
    checks++;
    if (d !== 16'h1234) begin
      errors++;
      $display("FAIL ram_rw: read %h, want 1234", d);
    end
    dmemaddr = 16'h0010; dmemwdata = 16'h5678; dmemwrite = 1'b1; dmemread = 1'b1;
    #1;
    checks++;
    if (dmemrdata !== 16'h1234) begin
      errors++;
      $display("FAIL rw_collision_old: read %h, want 1234", dmemrdata);
    end
    tick();
    dmemwrite = 1'b0;
    #1;
    checks++;
    if (dmemrdata !== 16'h5678) begin
      errors++;
      $display("FAIL rw_collision_new: read %h, want 5678", dmemrdata);
    end
    cpu_write(16'h01FE, 16'hCAFE);
    cpu_read(16'h01FE, d);
    checks++;
    if (d !== 16'hCAFE) begin
      errors++;
      $display("FAIL ram_last_word: read %h, want cafe", d);
    end
    cpu_read(16'h0000, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL ram_word0_untouched: read %h, want 0000", d);
    end
    idle();
  endtask

  task automatic test_errors;
    logic [15:0] d, c0, c1;
    checks++;
    if (err_misalign !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_before: errm=%b errr=%b, want 0/0", err_misalign, err_range);
    end
    cpu_write(16'h0011, 16'hBEEF);
    checks++;
    if (err_misalign !== 1'b1 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL misalign_flag: errm=%b errr=%b, want 1/0", err_misalign, err_range);
    end
    cpu_read(16'h0010, d);
    checks++;
    if (d !== 16'h5678) begin
      errors++;
      $display("FAIL misalign_no_write: read %h, want 5678", d);
    end
    cpu_read(16'h0011, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL misalign_read: read %h, want 0000", d);
    end
    cpu_read(16'h0200, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL unmapped_read: read %h, want 0000", d);
    end
    tick();
    checks++;
    if (err_range !== 1'b1 || err_misalign !== 1'b1) begin
      errors++;
      $display("FAIL range_flag: errm=%b errr=%b, want 1/1", err_misalign, err_range);
    end
    dmemaddr = 16'hFFFE; dmemwdata = 16'hAAAA; dmemwrite = 1'b1; dmemread = 1'b1;
    #1;
    c0 = dmemrdata;
    tick();
    dmemwrite = 1'b0;
    #1;
    c1 = dmemrdata;
    checks++;
    if (c1 !== 16'(c0 + 16'd1)) begin
      errors++;
      $display("FAIL cycles_write_ignored: got %h after %h, want +1", c1, c0);
    end
    idle();
  endtask

  task automatic test_ioport;
    logic [15:0] d;
    dmemaddr = 16'hFFFC; dmemwdata = 16'hBEEF; dmemwrite = 1'b1;
    #1;
    checks++;
    if (ioport !== 16'h0000) begin
      errors++;
      $display("FAIL ioport_before: ioport=%h, want 0000", ioport);
    end
    tick();
    dmemwrite = 1'b0;
    checks++;
    if (ioport !== 16'hBEEF) begin
      errors++;
      $display("FAIL ioport_write: ioport=%h, want beef", ioport);
    end
    cpu_read(16'hFFFC, d);
    checks++;
    if (d !== 16'hBEEF) begin
      errors++;
      $display("FAIL ioport_read: read %h, want beef", d);
    end
    idle();
  endtask

  task automatic test_counter;
    logic [15:0] c0, c1;
    cpu_read(16'hFFFE, c0);
    for (int i = 0; i < 37; i++) tick();
    #1;
    c1 = dmemrdata;
    checks++;
    if (16'(c1 - c0) !== 16'd37) begin
      errors++;
      $display("FAIL cycles_delta: diff %0d, want 37", 16'(c1 - c0));
    end
    c0 = c1;
    for (int i = 0; i < 65536; i++) tick();
    #1;
    c1 = dmemrdata;
    checks++;
    if (c1 !== c0) begin
      errors++;
      $display("FAIL cycles_wrap: got %h, want %h", c1, c0);
    end
    idle();
  endtask

  task automatic test_reset_mid_init;
    int n, bad;
    logic [15:0] d;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_ready: ready=%b, want 0", ready);
    end
    wait_ready(n, bad);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL mid_init_latency: ready after %0d edges, want 256", n);
    end
    cpu_read(16'h01FE, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL mid_init_ram: read %h, want 0000", d);
    end
    idle();
  endtask

  task automatic test_reset_run;
    int n, bad;
    logic [15:0] d;
    cpu_write(16'h0020, 16'h1111);
    cpu_write(16'hFFFC, 16'h7777);
    cpu_write(16'h0401, 16'h0000);
    cpu_write(16'h0400, 16'h0000);
    reset = 1'b1;
    dmemaddr = 16'h0020; dmemwdata = 16'hDEAD; dmemwrite = 1'b1;
    tick();
    reset = 1'b0;
    dmemwrite = 1'b0;
    checks++;
    if (ready !== 1'b0 || ioport !== 16'h0 || err_misalign !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_state: ready=%b ioport=%h errm=%b errr=%b, want 0/0000/0/0",
               ready, ioport, err_misalign, err_range);
    end
    wait_ready(n, bad);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL run_reset_latency: ready after %0d edges, want 256", n);
    end
    cpu_read(16'h0020, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL run_reset_ram: read %h, want 0000", d);
    end
    cpu_read(16'hFFFE, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL run_reset_cycles: read %h, want 0000", d);
    end
    cpu_read(16'hFFFF, d);
    tick();
    checks++;
    if (err_misalign !== 1'b1 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL odd_unmapped: errm=%b errr=%b, want 1/0", err_misalign, err_range);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_ram();
    test_errors();
    test_ioport();
    test_counter();
    test_reset_mid_init();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
